i2c_cmd_arbiter: RTL and testbench

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

---
 rtl/i2c_cmd_arbiter.sv | 112 +++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter.sv
// Two-port command arbiter in front of a single I2C register driver.
// Round-robin grant, one command in flight, per-command completion timeout.
module i2c_cmd_arbiter #(
  parameter logic [19:0] TIMEOUT_CYC = 20'd100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_rh_wl,
  input  logic [15:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_rh_wl,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  input  logic        p1_block,
  output logic [7:0]  rdata,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic        i2c_done,
  input  logic [7:0]  i2c_data_r,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      r_state, w_next;
  logic        r_gnt, r_last, r_rh_wl, r_err;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata, r_rdata;
  logic [19:0] r_cnt;
  logic        w_e0, w_e1, w_any, w_win, w_timeout;

  assign w_e0      = p0_req;
  assign w_e1      = p1_req & ~p1_block;
  assign w_any     = w_e0 | w_e1;
  // On a tie the port that did not win last time gets the grant.
  assign w_win     = (w_e0 & w_e1) ? ~r_last : w_e1;
  assign w_timeout = (r_cnt == TIMEOUT_CYC - 20'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (i2c_done || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_rh_wl <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_rh_wl <= w_win ? p1_rh_wl : p0_rh_wl;
            r_addr  <= w_win ? p1_addr  : p0_addr;
            r_wdata <= w_win ? p1_wdata : p0_wdata;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          // done takes priority over a coincident timeout
          if (i2c_done) begin
            if (r_rh_wl) r_rdata <= i2c_data_r;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        RESP: r_last <= r_gnt;
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign i2c_exec   = (r_state == ISSUE);
  assign i2c_rh_wl  = r_rh_wl;
  assign i2c_addr   = r_addr;
  assign i2c_data_w = r_wdata;
  assign rdata      = r_rdata;
  assign p0_ack     = (r_state == RESP) & ~r_gnt;
  assign p1_ack     = (r_state == RESP) &  r_gnt;
  assign p0_err     = p0_ack & r_err;
  assign p1_err     = p1_ack & r_err;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: a default-timeout instance for the
// functional steps and a TIMEOUT_CYC=20 instance for the timeout steps.
module tb_i2c_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_rh_wl, p1_req, p1_rh_wl, p1_block;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        i2c_done, t_done;
  logic [7:0]  i2c_data_r;

  logic        p0_ack, p0_err, p1_ack, p1_err, i2c_exec, i2c_rh_wl, busy;
  logic [7:0]  rdata, i2c_data_w;
  logic [15:0] i2c_addr;
  logic        t_p0_ack, t_p0_err, t_p1_ack, t_p1_err, t_exec, t_rh_wl, t_busy;
  logic [7:0]  t_rdata, t_data_w;
  logic [15:0] t_addr;

  i2c_cmd_arbiter u_dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_rh_wl(p0_rh_wl), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_rh_wl(p1_rh_wl), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_block(p1_block), .rdata(rdata),
    .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
    .i2c_data_w(i2c_data_w), .i2c_done(i2c_done), .i2c_data_r(i2c_data_r), .busy(busy)
  );

  i2c_cmd_arbiter #(.TIMEOUT_CYC(20'd20)) u_dut_to (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_rh_wl(p0_rh_wl), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(t_p0_ack), .p0_err(t_p0_err),
    .p1_req(p1_req), .p1_rh_wl(p1_rh_wl), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(t_p1_ack), .p1_err(t_p1_err), .p1_block(p1_block), .rdata(t_rdata),
    .i2c_exec(t_exec), .i2c_rh_wl(t_rh_wl), .i2c_addr(t_addr),
    .i2c_data_w(t_data_w), .i2c_done(t_done), .i2c_data_r(i2c_data_r), .busy(t_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       port;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_exec = 0;
  logic [7:0] m_rdata = 8'h00;

  always @(negedge clk) if (i2c_exec === 1'b1) n_exec++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic err);
    exp_t e;
    e.port = port; e.err = err; e.rdata = m_rdata;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag, input logic a0, input logic a1,
                           input logic e0, input logic e1, input logic [7:0] rd);
    exp_t e;
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_p0_ack"}, a0, !e.port);
    chk({tag, "_p1_ack"}, a1, e.port);
    chk({tag, "_p0_err"}, e0, e.port ? 1'b0 : e.err);
    chk({tag, "_p1_err"}, e1, e.port ? e.err : 1'b0);
    chk({tag, "_rdata"}, rd, e.rdata);
  endtask

  task automatic drive_req(input logic port, input logic rd, input logic [15:0] addr,
                           input logic [7:0] wd);
    if (port) begin
      p1_req = 1'b1; p1_rh_wl = rd; p1_addr = addr; p1_wdata = wd;
    end else begin
      p0_req = 1'b1; p0_rh_wl = rd; p0_addr = addr; p0_wdata = wd;
    end
  endtask

  // One command on the default instance; driver answers dly cycles after exec.
  task automatic run_cmd(input string tag, input logic port, input logic rd,
                         input logic [15:0] addr, input logic [7:0] wd,
                         input int dly, input logic [7:0] drd);
    int ex0;
    if (rd) m_rdata = drd;
    push_exp(port, 1'b0);
    ex0 = n_exec;
    drive_req(port, rd, addr, wd);
    @(negedge clk);
    chk({tag, "_exec"}, i2c_exec, 1);
    chk({tag, "_addr"}, i2c_addr, addr);
    chk({tag, "_data_w"}, i2c_data_w, wd);
    chk({tag, "_rh_wl"}, i2c_rh_wl, rd);
    repeat (dly) @(negedge clk);
    i2c_done = 1'b1; i2c_data_r = drd;
    @(negedge clk);
    i2c_done = 1'b0; i2c_data_r = 8'h00;
    chk({tag, "_ack_after_done"}, p0_ack | p1_ack, 1);
    chk({tag, "_addr_held"}, i2c_addr, addr);
    pop_check(tag, p0_ack, p1_ack, p0_err, p1_err, rdata);
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
    chk({tag, "_exec_pulses"}, n_exec - ex0, 1);
  endtask

  initial begin
    int   ex0;
    int   cnt;
    bit   found;
    logic acc;

    rst = 1'b1;
    p0_req = 0; p0_rh_wl = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_rh_wl = 0; p1_addr = '0; p1_wdata = '0;
    p1_block = 0; i2c_done = 0; t_done = 0; i2c_data_r = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_exec", i2c_exec, 0);
    chk("rst_acks", {p0_ack, p1_ack, p0_err, p1_err}, 0);
    chk("rst_bus", {i2c_rh_wl, i2c_addr, i2c_data_w, rdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd("p0_write", 1'b0, 1'b0, 16'h3008, 8'h82, 30, 8'h00);
    @(negedge clk);
    run_cmd("p1_read", 1'b1, 1'b1, 16'h300A, 8'h00, 5, 8'h56);
    @(negedge clk);

    // Both requesters held for four commands; last grant was p1.
    drive_req(1'b0, 1'b0, 16'h1000, 8'h11);
    drive_req(1'b1, 1'b0, 16'h2000, 8'h22);
    for (int i = 0; i < 4; i++) push_exp(i[0], 1'b0);
    ex0 = n_exec;
    for (int i = 0; i < 4; i++) begin
      found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
        @(negedge clk);
        if (i2c_exec === 1'b1) found = 1;
      end
      chk("rr_exec_seen", found, 1);
      chk("rr_order_addr", i2c_addr, i[0] ? 16'h2000 : 16'h1000);
      repeat (2) @(negedge clk);
      i2c_done = 1'b1;
      @(negedge clk);
      i2c_done = 1'b0;
      if (i == 3) begin p0_req = 0; p1_req = 0; end
      pop_check("rr", p0_ack, p1_ack, p0_err, p1_err, rdata);
    end
    repeat (5) @(negedge clk);
    chk("rr_exec_count", n_exec - ex0, 4);

    // p1 blocked: no grant for 1000 cycles, then one cycle of latency after release.
    p1_block = 1'b1;
    drive_req(1'b1, 1'b1, 16'h4000, 8'h00);
    ex0 = n_exec;
    repeat (1000) @(negedge clk);
    chk("block_no_exec", n_exec - ex0, 0);
    chk("block_idle", busy, 0);
    p1_block = 1'b0;
    m_rdata = 8'h9C;
    push_exp(1'b1, 1'b0);
    @(negedge clk);
    chk("unblock_exec", i2c_exec, 1);
    p1_block = 1'b1;
    repeat (3) @(negedge clk);
    i2c_done = 1'b1; i2c_data_r = 8'h9C;
    @(negedge clk);
    i2c_done = 1'b0; i2c_data_r = 8'h00; p1_req = 0;
    pop_check("block_mid", p0_ack, p1_ack, p0_err, p1_err, rdata);
    p1_block = 1'b0;
    @(negedge clk);

    run_cmd("p0_read", 1'b0, 1'b1, 16'h5000, 8'h00, 3, 8'h3C);
    @(negedge clk);

    // Reset in WAIT of a p1 read: abandoned, late done ignored, cold-start tie.
    drive_req(1'b1, 1'b1, 16'h300A, 8'h00);
    @(negedge clk);
    chk("rstmid_exec", i2c_exec, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1; p1_req = 0;
    #1;
    m_rdata = 8'h00;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_outs", {i2c_exec, p0_ack, p1_ack, p0_err, p1_err}, 0);
    chk("rstmid_bus", {i2c_rh_wl, i2c_addr, i2c_data_w, rdata}, 0);
    @(negedge clk);
    rst = 1'b0;
    i2c_done = 1'b1; i2c_data_r = 8'hEE;
    @(negedge clk);
    i2c_done = 1'b0; i2c_data_r = 8'h00;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      acc = acc | p0_ack | p1_ack | busy;
    end
    chk("rstmid_no_ack", acc, 0);
    chk("rstmid_rdata", rdata, 0);
    drive_req(1'b0, 1'b0, 16'h6000, 8'h66);
    drive_req(1'b1, 1'b0, 16'h7000, 8'h77);
    push_exp(1'b0, 1'b0);
    @(negedge clk);
    chk("cold_exec", i2c_exec, 1);
    chk("cold_tie_p0", i2c_addr, 16'h6000);
    repeat (2) @(negedge clk);
    i2c_done = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0; p0_req = 0; p1_req = 0;
    pop_check("cold", p0_ack, p1_ack, p0_err, p1_err, rdata);

    // Timeout instance starts clean.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_rdata = 8'h00;
    @(negedge clk);

    push_exp(1'b0, 1'b1);
    drive_req(1'b0, 1'b0, 16'h3008, 8'h82);
    @(negedge clk);
    chk("to_exec", t_exec, 1);
    chk("to_busy", t_busy, 1);
    chk("to_bus", {t_rh_wl, t_addr, t_data_w}, {1'b0, 16'h3008, 8'h82});
    cnt = 0; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      cnt++;
      if ((t_p0_ack | t_p1_ack) === 1'b1) found = 1;
    end
    chk("to_ack_seen", found, 1);
    chk("to_ack_cycle", cnt, 21);
    p0_req = 0;
    pop_check("to_err", t_p0_ack, t_p1_ack, t_p0_err, t_p1_err, t_rdata);
    @(negedge clk);

    m_rdata = 8'hA5;
    push_exp(1'b0, 1'b0);
    drive_req(1'b0, 1'b1, 16'h300A, 8'h00);
    @(negedge clk);
    chk("to2_exec", t_exec, 1);
    repeat (20) @(negedge clk);
    t_done = 1'b1; i2c_data_r = 8'hA5;
    @(negedge clk);
    t_done = 1'b0; i2c_data_r = 8'h00; p0_req = 0;
    chk("to2_ack", t_p0_ack, 1);
    pop_check("to2_done_wins", t_p0_ack, t_p1_ack, t_p0_err, t_p1_err, t_rdata);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
